// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings and controller state for the data memory
package mem_pkg;
  localparam int INSTRUCTION_LEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/byte_lane_align.sv
// rtl/byte_lane_align.sv - big-endian load extraction/extension and store lane generation
module byte_lane_align import mem_pkg::*; (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_signed,
  input  logic [31:0] rd_word,
  input  logic [31:0] wd,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic [3:0]  byte_en
);
  logic [7:0]  b;
  logic [15:0] h;

  // byte_en[k] and store_word lane k address byte off_base+k; lane 0 is the MSB
  always_comb begin
    b = 8'h00;
    case (off)
      2'd0:    b = rd_word[31:24];
      2'd1:    b = rd_word[23:16];
      2'd2:    b = rd_word[15:8];
      default: b = rd_word[7:0];
    endcase
  end

  assign h = off[1] ? rd_word[15:0] : rd_word[31:16];

  always_comb begin
    load_data  = '0;
    store_word = wd;
    byte_en    = 4'b0000;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{is_signed & b[7]}}, b};
        store_word = {4{wd[7:0]}};
        byte_en    = 4'b0001 << off;
      end
      SZ_HALF: begin
        load_data  = {{16{is_signed & h[15]}}, h};
        store_word = {2{wd[15:0]}};
        byte_en    = off[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        load_data  = rd_word;
        byte_en    = 4'b1111;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressed big-endian data memory with wait-state handshake
module data_mem_ctrl import mem_pkg::*; #(
  parameter int          DATA_W      = INSTRUCTION_LEN,
  parameter int          DEPTH_BYTES = 2048,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              ready,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] read_data
);
  localparam int AW = $clog2(DEPTH_BYTES);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] addr_q, wd_q;
  logic [1:0]        size_q;
  logic              write_q, signed_q, err_q;
  logic              accept, commit;

  logic [7:0]        mem [DEPTH_BYTES];

  // In IDLE the live request is decoded so a zero-wait access can commit at acceptance
  logic              idle;
  logic [DATA_W-1:0] a_addr, a_wd, off;
  logic [1:0]        a_size;
  logic              a_write, a_signed, oow, misal, err;
  logic [AW-3:0]     word_idx;
  logic [31:0]       rd_word, load_data, store_word;
  logic [3:0]        byte_en;

  assign idle     = (state == IDLE);
  assign a_addr   = idle ? addr       : addr_q;
  assign a_wd     = idle ? write_data : wd_q;
  assign a_size   = idle ? req_size   : size_q;
  assign a_write  = idle ? req_write  : write_q;
  assign a_signed = idle ? req_signed : signed_q;

  assign off      = a_addr - BASE_ADDR;
  assign oow      = (a_addr < BASE_ADDR) || (off >= DATA_W'(DEPTH_BYTES));
  assign misal    = ((a_size == SZ_HALF) && a_addr[0]) ||
                    ((a_size == SZ_WORD) && (a_addr[1:0] != 2'b00));
  assign err      = oow || misal || (a_size == 2'd3);
  assign word_idx = off[AW-1:2];
  assign rd_word  = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                     mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};

  byte_lane_align u_align (
    .size       (a_size),
    .off        (off[1:0]),
    .is_signed  (a_signed),
    .rd_word    (rd_word),
    .wd         (a_wd),
    .load_data  (load_data),
    .store_word (store_word),
    .byte_en    (byte_en)
  );

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (err) begin
            state_nxt = RESP;
          end else if (WAIT_STATES == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_err = rsp_valid & err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      read_data <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      size_q    <= 2'd0;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q   <= addr;
        wd_q     <= write_data;
        size_q   <= req_size;
        write_q  <= req_write;
        signed_q <= req_signed;
        err_q    <= err;
        if (err) read_data <= '0;
        else if (WAIT_STATES != 0) cnt <= 4'(WAIT_STATES - 1);
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !a_write) read_data <= load_data;
    end
  end

  // Storage survives reset; an aborted access never reaches a commit edge
  always_ff @(posedge clk) begin
    if (commit && a_write) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[{word_idx, 2'(k)}] <= store_word[8*(3-k) +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl with one and zero wait states
module tb_data_mem_ctrl;
  typedef struct {
    logic        err;
    logic        chkd;
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q0[$];

  logic        req_valid1 = 1'b0, req_write1 = 1'b0, req_signed1 = 1'b0;
  logic [1:0]  req_size1 = 2'd0;
  logic [31:0] addr1 = '0, write_data1 = '0;
  logic        ready1, rsp_valid1, rsp_err1;
  logic [31:0] read_data1;

  logic        req_valid0 = 1'b0, req_write0 = 1'b0, req_signed0 = 1'b0;
  logic [1:0]  req_size0 = 2'd0;
  logic [31:0] addr0 = '0, write_data0 = '0;
  logic        ready0, rsp_valid0, rsp_err0;
  logic [31:0] read_data0;

  logic        t_w   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [1:0]  t_sz  [6] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2};
  logic        t_sg  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] t_a   [6] = '{32'h410, 32'h410, 32'h412, 32'h412, 32'h3FF, 32'h410};
  logic [31:0] t_wd  [6] = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        t_err [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        t_chk [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] t_exp [6] = '{32'h0, 32'hCAFEF00D, 32'h0000F00D, 32'hFFFFF00D, 32'h0, 32'hCAFEF00D};

  data_mem_ctrl #(.WAIT_STATES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_write(req_write1),
    .req_size(req_size1), .req_signed(req_signed1), .addr(addr1), .write_data(write_data1),
    .ready(ready1), .rsp_valid(rsp_valid1), .rsp_err(rsp_err1), .read_data(read_data1)
  );

  data_mem_ctrl #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_write(req_write0),
    .req_size(req_size0), .req_signed(req_signed0), .addr(addr0), .write_data(write_data0),
    .ready(ready0), .rsp_valid(rsp_valid0), .rsp_err(rsp_err0), .read_data(read_data0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rsp_valid1) begin
      if (q1.size() == 0) chk("u1_spurious_rsp", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("u1_rsp_err", 32'(rsp_err1), 32'(e.err));
        if (e.chkd) chk("u1_read_data", read_data1, e.data);
        chk("u1_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rsp_valid0) begin
      if (q0.size() == 0) chk("u0_spurious_rsp", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("u0_rsp_err", 32'(rsp_err0), 32'(e.err));
        if (e.chkd) chk("u0_read_data", read_data0, e.data);
        chk("u0_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic req1(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic e_err, input logic chkd, input logic [31:0] e_data);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready1) chk("u1_ready_timeout", 32'd0, 32'd1);
    req_write1  = w;
    req_size1   = sz;
    req_signed1 = sg;
    addr1       = a;
    write_data1 = wd;
    req_valid1  = 1'b1;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    e.err  = e_err;
    e.chkd = chkd;
    e.data = e_data;
    e.acc  = cyc;
    e.lat  = e_err ? 1 : 2;
    q1.push_back(e);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready1) break;
      n++;
    end
    chk("u1_ready_low_cycles", 32'(n), 32'(e.lat));
  endtask

  initial begin
    int   n;
    int   prev;
    exp_t e;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready1", 32'(ready1), 32'd1);
    chk("rst_rsp_valid1", 32'(rsp_valid1), 32'd0);
    chk("rst_rsp_err1", 32'(rsp_err1), 32'd0);
    chk("rst_read_data1", read_data1, 32'd0);
    chk("rst_ready0", 32'(ready0), 32'd1);
    chk("rst_rsp_valid0", 32'(rsp_valid0), 32'd0);
    chk("rst_read_data0", read_data0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // known contents, then a store aborted by reset while in BUSY
    req1(1'b1, 2'd2, 1'b0, 32'h400, 32'h11223344, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    req_write1  = 1'b1;
    req_size1   = 2'd2;
    addr1       = 32'h400;
    write_data1 = 32'hDEADBEEF;
    req_valid1  = 1'b1;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("abort_ready", 32'(ready1), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid1), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req1(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0, 1'b1, 32'h11223344);

    // word store/load, then sub-word loads with extension
    req1(1'b1, 2'd2, 1'b0, 32'h404, 32'hC0000000, 1'b0, 1'b0, 32'h0);
    req1(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 1'b0, 1'b1, 32'hC0000000);
    req1(1'b1, 2'd2, 1'b0, 32'h408, 32'h80FF1234, 1'b0, 1'b0, 32'h0);
    req1(1'b0, 2'd0, 1'b1, 32'h408, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80);
    req1(1'b0, 2'd0, 1'b0, 32'h409, 32'h0, 1'b0, 1'b1, 32'h000000FF);
    req1(1'b0, 2'd1, 1'b1, 32'h40A, 32'h0, 1'b0, 1'b1, 32'h00001234);
    req1(1'b0, 2'd1, 1'b1, 32'h408, 32'h0, 1'b0, 1'b1, 32'hFFFF80FF);

    // byte store into the middle of a word
    req1(1'b1, 2'd2, 1'b0, 32'h40C, 32'h01020304, 1'b0, 1'b0, 32'h0);
    req1(1'b1, 2'd0, 1'b0, 32'h40D, 32'h555555AB, 1'b0, 1'b0, 32'h0);
    req1(1'b0, 2'd2, 1'b0, 32'h40C, 32'h0, 1'b0, 1'b1, 32'h01AB0304);

    // error accesses; 0xC00 aliases offset 0 if the window check leaks
    req1(1'b0, 2'd1, 1'b0, 32'h401, 32'h0, 1'b1, 1'b1, 32'h0);
    req1(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 1'b1, 1'b1, 32'h0);
    req1(1'b1, 2'd2, 1'b0, 32'hC00, 32'hBAADF00D, 1'b1, 1'b1, 32'h0);
    req1(1'b0, 2'd3, 1'b0, 32'h400, 32'h0, 1'b1, 1'b1, 32'h0);
    req1(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0, 1'b1, 32'h11223344);

    // zero wait states, req_valid held high, junk presented while busy
    @(negedge clk);
    prev = 0;
    req_valid0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (!ready0 && n < 20) begin
        req_write0  = 1'b1;
        req_size0   = 2'd2;
        addr0       = 32'h410;
        write_data0 = 32'hBADBAD00;
        @(negedge clk);
        n++;
      end
      if (!ready0) chk("u0_ready_timeout", 32'd0, 32'd1);
      req_write0  = t_w[i];
      req_size0   = t_sz[i];
      req_signed0 = t_sg[i];
      addr0       = t_a[i];
      write_data0 = t_wd[i];
      @(posedge clk);
      #1;
      e.err  = t_err[i];
      e.chkd = t_chk[i];
      e.data = t_exp[i];
      e.acc  = cyc;
      e.lat  = 1;
      q0.push_back(e);
      if (i > 0) chk("u0_accept_gap", 32'(cyc - prev), 32'd2);
      prev = cyc;
      @(negedge clk);
    end
    req_valid0 = 1'b0;

    for (int k = 0; k < 20 && (q0.size() + q1.size()) != 0; k++) @(negedge clk);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
